// File: rtl/sip_prefix_match_tree.sv
// Source-IP prefix match: 4-level byte-wise tree over a fixed 8-rule table.
// Each level ANDs its per-rule byte compare into the match vector. Output is registered.

module sip_prefix_level #(
  parameter int                          NUM_RULE_ID = 8,
  parameter int                          LVL         = 0,
  parameter logic [32*NUM_RULE_ID-1:0]   RULE_PREFIX = '0,
  parameter logic [6*NUM_RULE_ID-1:0]    RULE_LEN    = '0
) (
  input  logic [7:0]             fld,
  output logic [NUM_RULE_ID-1:0] hit
);
  for (genvar k = 0; k < NUM_RULE_ID; k++) begin : g_rule
    localparam int          RAW  = int'(RULE_LEN[6*k +: 6]);
    localparam int          LEN  = (RAW > 32) ? 32 : RAW;
    // Upper LEN bits set; a length of 0 yields an all-zero mask and matches everything.
    localparam logic [31:0] MASK = ~(32'hFFFF_FFFF >> LEN);
    localparam logic [7:0]  MB   = MASK[31-8*LVL -: 8];
    localparam logic [7:0]  PB   = RULE_PREFIX[32*k+31-8*LVL -: 8];
    assign hit[k] = ((fld ^ PB) & MB) == 8'h00;
  end
endmodule

module sip_prefix_match_tree #(
  parameter int                          NUM_RULE_ID   = 8,
  parameter int                          RULE_ID_WIDTH = 3,
  parameter logic [32*NUM_RULE_ID-1:0]   RULE_PREFIX   = {32'hAC10_0000, 32'hC0A8_2200,
                                                          32'h0A00_0000, 32'h0000_0000,
                                                          32'hC000_0000, 32'hC0A8_0000,
                                                          32'hC0A8_2100, 32'hC0A8_2141},
  parameter logic [6*NUM_RULE_ID-1:0]    RULE_LEN      = {6'd12, 6'd24, 6'd8, 6'd0,
                                                          6'd8,  6'd16, 6'd24, 6'd32}
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [0:32]                         in,
  output logic [0:NUM_RULE_ID*(RULE_ID_WIDTH+1)-1] out
);
  localparam int LEVELS = 4;
  localparam int EW     = RULE_ID_WIDTH + 1;

  logic [LEVELS-1:0]                  vld_pipe;
  logic [LEVELS-1:0][NUM_RULE_ID-1:0] match_q;
  logic [LEVELS-1:0][NUM_RULE_ID-1:0] hit;
  logic [LEVELS-1:0][7:0]             fld;
  // Fields not yet consumed ride along with the match vector.
  logic [7:0] f1_q0, f2_q0, f3_q0, f2_q1, f3_q1, f3_q2;
  logic [0:NUM_RULE_ID*EW-1]          out_d;

  assign fld[0] = in[1:8];
  assign fld[1] = f1_q0;
  assign fld[2] = f2_q1;
  assign fld[3] = f3_q2;

  for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
    sip_prefix_level #(
      .NUM_RULE_ID (NUM_RULE_ID),
      .LVL         (s),
      .RULE_PREFIX (RULE_PREFIX),
      .RULE_LEN    (RULE_LEN)
    ) u_lvl (
      .fld (fld[s]),
      .hit (hit[s])
    );
  end

  always_comb begin
    out_d = '0;
    for (int k = 0; k < NUM_RULE_ID; k++) begin
      if (vld_pipe[LEVELS-1] && match_q[LEVELS-1][k]) begin
        out_d[EW*k]          = 1'b1;
        out_d[EW*k+1 +: RULE_ID_WIDTH] = RULE_ID_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      match_q  <= '0;
      f1_q0    <= '0;
      f2_q0    <= '0;
      f3_q0    <= '0;
      f2_q1    <= '0;
      f3_q1    <= '0;
      f3_q2    <= '0;
      out      <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[LEVELS-2:0], in[0]};
      match_q[0] <= {NUM_RULE_ID{in[0]}} & hit[0];
      for (int s = 1; s < LEVELS; s++)
        match_q[s] <= match_q[s-1] & hit[s];
      f1_q0 <= in[9:16];
      f2_q0 <= in[17:24];
      f3_q0 <= in[25:32];
      f2_q1 <= f2_q0;
      f3_q1 <= f3_q0;
      f3_q2 <= f3_q1;
      out   <= out_d;
    end
  end
endmodule

// File: tb/tb_sip_prefix_match_tree.sv
// Scoreboard bench for sip_prefix_match_tree: expected out queued at drive time,
// popped when the packet reaches out four edges later.

module tb_sip_prefix_match_tree;
  logic        clk;
  logic        reset;
  logic [0:32] in_s;
  logic [0:31] out_s;

  int checks = 0;
  int errors = 0;

  logic [31:0] pend[$];
  string       ptag[$];

  logic [31:0] tpfx[8] = '{32'hC0A8_2141, 32'hC0A8_2100, 32'hC0A8_0000, 32'hC000_0000,
                           32'h0000_0000, 32'h0A00_0000, 32'hC0A8_2200, 32'hAC10_0000};
  int          tlen[8] = '{32, 24, 16, 8, 0, 8, 24, 12};

  sip_prefix_match_tree dut (
    .clk   (clk),
    .reset (reset),
    .in    (in_s),
    .out   (out_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic v, input logic [31:0] ip);
    logic [31:0] r;
    logic        m;
    r = '0;
    if (v) begin
      for (int k = 0; k < 8; k++) begin
        m = 1'b1;
        for (int b = 0; b < tlen[k] && b < 32; b++)
          if (ip[31-b] != tpfx[k][31-b]) m = 1'b0;
        if (m) r[31-4*k -: 4] = {1'b1, 3'(k)};
      end
    end
    return r;
  endfunction

  // One clock: drive at negedge, then settle the scoreboard just after the posedge.
  task automatic step(input logic rst, input logic v, input logic [31:0] ip,
                      input logic [31:0] exp, input string tag);
    logic [31:0] e;
    string       t;
    @(negedge clk);
    reset = rst;
    if (rst) in_s = 'x;
    else     in_s = {v, ip};
    @(posedge clk);
    #1;
    if (rst) begin
      pend.delete();
      ptag.delete();
      for (int i = 0; i < 4; i++) begin
        pend.push_back(32'h0);
        ptag.push_back("flushed");
      end
      chk("reset_out", out_s, 32'h0);
    end else begin
      pend.push_back(exp);
      ptag.push_back(tag);
      if (pend.size() >= 5) begin
        e = pend.pop_front();
        t = ptag.pop_front();
        chk(t, out_s, e);
      end
    end
  endtask

  task automatic pkt(input logic [31:0] ip, input logic [31:0] exp, input string tag);
    step(1'b0, 1'b1, ip, exp, tag);
  endtask

  task automatic bubble();
    step(1'b0, 1'b0, 32'h0, 32'h0, "bubble");
  endtask

  initial begin
    logic [31:0] ip;
    logic        v;
    reset = 1'b1;
    in_s  = 'x;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 32'h0, "");
    for (int i = 0; i < 4; i++) bubble();

    // Held hit set
    for (int i = 0; i < 6; i++) pkt(32'hC0A8_2141, 32'h89AB_C000, "hit_192.168.33.65");

    pkt(32'hAC14_0101, 32'h0000_C00F, "p12_172.20.1.1");
    pkt(32'h0A01_0203, 32'h0000_CD00, "p8_10.1.2.3");
    pkt(32'hAC20_0101, 32'h0000_C000, "p12_miss_172.32.1.1");

    // Back-to-back
    pkt(32'hC0A8_2209, 32'h00AB_C0E0, "b2b_192.168.34.9");
    pkt(32'h0808_0808, 32'h0000_C000, "b2b_8.8.8.8");
    pkt(32'hC0A8_2142, 32'h09AB_C000, "b2b_192.168.33.66");

    // Valid / invalid / valid
    pkt(32'h0A01_0203, 32'h0000_CD00, "vbv_first");
    bubble();
    pkt(32'hC0A8_2141, 32'h89AB_C000, "vbv_last");
    for (int i = 0; i < 4; i++) bubble();

    // Flush two packets in flight
    pkt(32'hC0A8_2141, 32'h89AB_C000, "flushed_a");
    pkt(32'hAC14_0101, 32'h0000_C00F, "flushed_b");
    step(1'b1, 1'b0, 32'h0, 32'h0, "");
    for (int i = 0; i < 6; i++) bubble();

    // Random plus near-prefix single-bit flips
    for (int i = 0; i < 60; i++) begin
      v = ($urandom_range(3) != 0);
      if ($urandom_range(1) != 0) ip = $urandom();
      else ip = tpfx[$urandom_range(7)] ^ (32'h1 << $urandom_range(31));
      step(1'b0, v, ip, model(v, ip), "rand");
    end
    for (int i = 0; i < 5; i++) bubble();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sip_prefix_match_tree.md
# sip_prefix_match_tree

Source-IP (SIP) prefix-match stage of the packet-classification pipeline. It accepts one valid-tagged 32-bit IPv4 source address per clock and matches it against a fixed 8-rule prefix table. Matching runs through a 4-level byte-wise tree pipeline, one 8-bit field per level. It emits the set of matching rule IDs, each with its own valid bit, for downstream field-intersection logic.

## Interface

Parameters:
- `NUM_RULE_ID`, default 8: number of rules (fixed at 8).
- `RULE_ID_WIDTH`, default 3: rule ID width, log2(8).
- `RULE_PREFIX`, default {172.16.0.0, 192.168.34.0, 10.0.0.0, 0.0.0.0, 192.0.0.0, 192.168.0.0, 192.168.33.0, 192.168.33.65}: 256-bit packed prefix table. Rule k occupies bits [32k+31:32k], first octet in the MSB; the list runs rule 7 down to rule 0.
- `RULE_LEN`, default {12, 24, 8, 0, 8, 16, 24, 32}: 48-bit packed prefix-length table, 6 bits per rule. Rule k occupies bits [6k+5:6k], rule 7 down to rule 0. Values above 32 are treated as 32.

Ports:
- `clk`, input, 1 bit: single clock. All logic is rising-edge.
- `reset`, input, 1 bit: synchronous, active-high.
- `in`, input, [0:32]:
  - bit 0: valid.
  - [1:8]: IP field 0, the first octet.
  - [9:16]: field 1.
  - [17:24]: field 2.
  - [25:32]: field 3.
- `out`, output, [0:31]: 8 entries, entry k = bits [4k:4k+3].
  - Bit 4k: match-valid.
  - Bits [4k+1:4k+3]: rule ID, which equals k when valid and 3'b000 when not valid.

## Operation

- Per-rule mask: the upper `RULE_LEN[k]` bits of 32 are 1. Rule k matches when `(IP & mask) == (RULE_PREFIX[k] & mask)`. A length of 0 matches every address.
- Tree levels: level s (s = 0..3) compares field s against byte s of each rule's prefix, using byte s of that rule's mask. Partial-byte masks are supported, e.g. /12 in level 1.
- Match vector: each level ANDs its 8-bit per-rule result into the match vector received from the previous level. The vector enters level 0 as all-ones when the input is valid and all-zeros when it is not.
- The packet valid bit and the remaining IP fields travel alongside the match vector through every level.
- Output formation from the level-3 register:
  - For a valid packet, entry k valid = match[k] and ID = k.
  - For an invalid packet, all valid bits are 0 and all IDs are 0.
- Packets carry no ordering interaction. Every cycle is independent and the block never stalls; there is no backpressure.
- Default table with 192.168.33.65: rules 0, 1, 2, 3 and 4 match; rules 5, 6 and 7 do not.
- X or garbage on `in` while `reset`=1 is ignored.

## Timing

- Four pipeline register levels.
  - A packet sampled on `in` at rising edge N appears on `out` after rising edge N+4.
  - Throughput is one packet per clock.
- `out` is registered; there is no combinational path from `in` to `out`.
- Reset:
  - On any rising edge with `reset`=1, all level valid bits, match vectors, field registers and `out` clear to 0.
  - `out` reads 32'h0 on the edge after reset is first sampled high.
  - Reset mid-stream flushes all in-flight packets; none of them ever reaches `out`.
- First edge with `reset`=0 samples `in` normally.
- Invalid input (bit 0 = 0) produces an all-zero `out` four edges later, so bubbles propagate as zeros.

## Test plan

- Reset hold: assert `reset` for 3 cycles with `in`=X → `out`=32'h0 throughout, and for 4 edges after deassert while `in` stays invalid.
- Single hit set: after reset, drive valid 192.168.33.65 and hold it → from edge 4 onward, `out` entries 0–4 are valid with IDs 0–4, entries 5–7 are 0.
  - Expected `out` = {1000,1001,1010,1011,1100,0000,0000,0000}.
- Partial-byte and default rules:
  - 172.20.1.1 → only rules 4 and 7 valid.
  - 10.1.2.3 → only rules 4 and 5 valid.
- Back-to-back packets: drive 192.168.34.9, then 8.8.8.8, then 192.168.33.66 on consecutive cycles → on consecutive cycles, `out` shows:
  - {rules 2,3,4,6}
  - {rule 4}
  - {rules 1,2,3,4}
- Bubble and flush:
  - Valid, invalid, valid sequence → middle output is 32'h0.
  - Asserting `reset` with 2 packets in flight → neither packet ever appears on `out`.
